serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 91 +++++++++
 tb/tb_serial_frame_rx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: strobed serial receiver (start, MSB-first data, even parity, stop) with a one-word output buffer.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              bit_en,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic              par_q, par_d, valid_q, valid_d, perr_q, perr_d;
  logic              ferr_q, ferr_d, ovr_q, ovr_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q && !out_ready;
    perr_d  = perr_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: if (!sin) begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          sh_d    = {sh_q[DATA_W-2:0], sin};
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(DATA_W - 1)) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = sin;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          // a full buffer that is not drained this edge drops the new word
          if (!sin) ferr_d = 1'b1;
          else if (!valid_q || out_ready) begin
            data_d  = sh_q;
            perr_d  = ^sh_q ^ par_q;
            valid_d = 1'b1;
          end else ovr_d = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames with hand-computed expectations for serial_frame_rx.
module tb_serial_frame_rx;
  logic       clk = 1'b0;
  logic       rst, sin, bit_en, out_ready;
  logic [7:0] out_data;
  logic       out_valid, parity_err, frame_err, overrun, busy;
  int         n_cmp = 0;
  int         n_err = 0;
  serial_frame_rx #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // gap cycles with bit_en low drive the inverted bit, so a sample there would corrupt the frame
  task automatic send_bit(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b1;
    tick();
    if (gap > 0) begin
      bit_en = 1'b0;
      sin    = ~b;
      repeat (gap) tick();
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp, input int gap);
    send_bit(1'b0, gap);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
    send_bit(p, gap);
    sin    = stp;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask
  initial begin
    rst = 1'b1; sin = 1'b1; bit_en = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_data", out_data, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_flags", {5'd0, parity_err, frame_err, overrun}, 8'h00);
    rst = 1'b0;
    tick();
    // good 0xA5 frame, even parity
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    chk("a5_valid", {7'd0, out_valid}, 8'h01);
    chk("a5_data", out_data, 8'hA5);
    chk("a5_perr", {7'd0, parity_err}, 8'h00);
    chk("a5_busy", {7'd0, busy}, 8'h00);
    tick();
    chk("a5_consumed", {7'd0, out_valid}, 8'h00);
    // parity bit wrong
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    chk("par_data", out_data, 8'hA5);
    chk("par_perr", {7'd0, parity_err}, 8'h01);
    tick();
    // 0x01 has odd weight, parity bit 1 is correct
    send_frame(8'h01, 1'b1, 1'b1, 0);
    chk("p01_data", out_data, 8'h01);
    chk("p01_perr", {7'd0, parity_err}, 8'h00);
    tick();
    // bad stop bit
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    chk("ferr_pulse", {7'd0, frame_err}, 8'h01);
    chk("ferr_valid", {7'd0, out_valid}, 8'h00);
    chk("ferr_busy", {7'd0, busy}, 8'h00);
    chk("ferr_data", out_data, 8'h01);
    tick();
    chk("ferr_once", {7'd0, frame_err}, 8'h00);
    // overrun with a stalled consumer
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    chk("ov_first_valid", {7'd0, out_valid}, 8'h01);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    chk("ov_pulse", {7'd0, overrun}, 8'h01);
    chk("ov_data_kept", out_data, 8'hA5);
    chk("ov_valid_kept", {7'd0, out_valid}, 8'h01);
    tick();
    chk("ov_once", {7'd0, overrun}, 8'h00);
    chk("ov_hold", out_data, 8'hA5);
    out_ready = 1'b1;
    tick();
    chk("ov_drain", {7'd0, out_valid}, 8'h00);
    // drain and reload on the same edge keeps out_valid high
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    send_bit(1'b0, 0);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    out_ready = 1'b1;
    sin = 1'b1; bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    chk("reload_valid", {7'd0, out_valid}, 8'h01);
    chk("reload_data", out_data, 8'h00);
    tick();
    chk("reload_drain", {7'd0, out_valid}, 8'h00);
    // leave a nonzero word so reset clearing is visible
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    out_ready = 1'b0;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    bit_en = 1'b0;
    chk("mid_busy", {7'd0, busy}, 8'h01);
    rst = 1'b1; bit_en = 1'b1; sin = 1'b0;
    tick();
    rst = 1'b0; bit_en = 1'b0; sin = 1'b1; out_ready = 1'b1;
    chk("mrst_busy", {7'd0, busy}, 8'h00);
    chk("mrst_data", out_data, 8'h00);
    chk("mrst_valid", {7'd0, out_valid}, 8'h00);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    chk("mrst_3c", out_data, 8'h3C);
    chk("mrst_3c_perr", {7'd0, parity_err}, 8'h00);
    tick();
    // one strobe in three
    send_bit(1'b0, 2);
    chk("gap_busy", {7'd0, busy}, 8'h01);
    for (int i = 7; i >= 0; i--) send_bit(8'h3C >> i & 8'h01 ? 1'b1 : 1'b0, 2);
    chk("gap_still_busy", {7'd0, busy}, 8'h01);
    chk("gap_no_early", {7'd0, out_valid}, 8'h00);
    send_bit(1'b0, 2);
    sin = 1'b1; bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    chk("gap_valid", {7'd0, out_valid}, 8'h01);
    chk("gap_data", out_data, 8'h3C);
    chk("gap_perr", {7'd0, parity_err}, 8'h00);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
